// File: rtl/temp_sampler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : temp_sampler_pkg
// Brief    : Shared constants for the temperature sampler: FSM state
//            encoding, default timing/fault parameters and datapath widths.
// Revision : 1.0 - initial release
// ============================================================================
package temp_sampler_pkg;

    // Default timing and fault-detection parameters
    localparam int c_default_sample_period = 1000;
    localparam int c_default_timeout       = 64;
    localparam int c_default_fault_limit   = 3;

    // Datapath widths
    localparam int c_data_w = 8;
    localparam int c_sum_w  = 10;

    // Sampler FSM state encoding
    localparam int c_state_w = 2;
    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_st_idle   = 2'd0;
    localparam state_t c_st_req    = 2'd1;
    localparam state_t c_st_wait   = 2'd2;
    localparam state_t c_st_update = 2'd3;

endpackage
`default_nettype wire

// File: rtl/temp_avg4.sv
`default_nettype none
// ============================================================================
// Module   : temp_avg4
// Brief    : 4-tap sample history with a truncating moving average.
//            load_all broadcasts din into every tap; shift pushes din into
//            tap 0 and drops the oldest tap. avg is the floor of the mean.
// Revision : 1.0 - initial release
// ============================================================================
module temp_avg4
    import temp_sampler_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load_all,
    input  logic                shift,
    input  logic [c_data_w-1:0] din,
    output logic [c_data_w-1:0] avg
);

    logic [c_data_w-1:0] r_h0;
    logic [c_data_w-1:0] r_h1;
    logic [c_data_w-1:0] r_h2;
    logic [c_data_w-1:0] r_h3;
    logic [c_sum_w-1:0]  w_sum;

    // History taps: broadcast on the first sample so the average starts settled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h0 <= '0;
            r_h1 <= '0;
            r_h2 <= '0;
            r_h3 <= '0;
        end else if (load_all) begin
            r_h0 <= din;
            r_h1 <= din;
            r_h2 <= din;
            r_h3 <= din;
        end else if (shift) begin
            r_h0 <= din;
            r_h1 <= r_h0;
            r_h2 <= r_h1;
            r_h3 <= r_h2;
        end
    end

    // Sum is wide enough for four full-scale codes; divide by 4 drops the fraction
    assign w_sum = {2'b00, r_h0} + {2'b00, r_h1} + {2'b00, r_h2} + {2'b00, r_h3};
    assign avg   = w_sum[c_sum_w-1:2];

endmodule
`default_nettype wire

// File: rtl/temp_sampler.sv
`default_nettype none
// ============================================================================
// Module   : temp_sampler
// Brief    : Periodic ADC temperature sampler. Requests a conversion every
//            SAMPLE_PERIOD idle cycles, waits up to TIMEOUT cycles for data,
//            publishes a 4-sample moving average and latches a sticky sensor
//            fault after FAULT_LIMIT consecutive timeouts (reading forced to
//            0xFF while faulted so downstream logic fails safe).
// Revision : 1.0 - initial release
// ============================================================================
module temp_sampler
    import temp_sampler_pkg::*;
#(
    parameter int SAMPLE_PERIOD = c_default_sample_period,
    parameter int TIMEOUT       = c_default_timeout,
    parameter int FAULT_LIMIT   = c_default_fault_limit
) (
    input  logic                clk,
    input  logic                reset,
    output logic                adc_start,
    input  logic                adc_valid,
    input  logic [c_data_w-1:0] adc_data,
    output logic [c_data_w-1:0] reading,
    output logic                reading_valid,
    output logic                sensor_fault
);

    // One shared cycle counter serves both IDLE and WAIT; it clears on every state change
    localparam int c_cnt_max = (SAMPLE_PERIOD > TIMEOUT) ? SAMPLE_PERIOD : TIMEOUT;
    localparam int c_cnt_w   = $clog2(c_cnt_max);
    localparam int c_flt_w   = $clog2(FAULT_LIMIT + 1);

    localparam logic [c_cnt_w-1:0] c_idle_last = c_cnt_w'(SAMPLE_PERIOD - 1);
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_flt_w-1:0] c_flt_limit = c_flt_w'(FAULT_LIMIT);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_flt_w-1:0]  r_to_cnt;
    logic [c_flt_w-1:0]  w_to_cnt_next;
    logic                r_first;
    logic                w_capture;
    logic                w_timeout;
    logic                w_fault_next;
    logic                r_adc_start;
    logic                r_reading_valid;
    logic                r_fault;
    logic [c_data_w-1:0] r_reading;
    logic [c_data_w-1:0] w_avg;

    // Next-state decode; valid data wins over a timeout expiring in the same cycle
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (r_cnt == c_idle_last) w_state_next = c_st_req;
            end
            c_st_req: begin
                w_state_next = c_st_wait;
            end
            c_st_wait: begin
                if (adc_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = c_st_update;
                end else if (r_cnt == c_wait_last) begin
                    w_timeout    = 1'b1;
                    w_state_next = c_st_idle;
                end
            end
            c_st_update: begin
                w_state_next = c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // Consecutive-timeout tracking: cleared by good data, saturates at the fault limit
    always_comb begin
        w_to_cnt_next = r_to_cnt;
        if (w_capture) begin
            w_to_cnt_next = '0;
        end else if (w_timeout && (r_to_cnt != c_flt_limit)) begin
            w_to_cnt_next = r_to_cnt + 1'b1;
        end
        w_fault_next = r_fault | (w_to_cnt_next == c_flt_limit);
    end

    // State register and cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (w_state_next != r_state) ? '0 : r_cnt + 1'b1;
        end
    end

    // Registered outputs and fault bookkeeping; fail-safe value overrides any average
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt        <= '0;
            r_first         <= 1'b1;
            r_fault         <= 1'b0;
            r_adc_start     <= 1'b0;
            r_reading_valid <= 1'b0;
            r_reading       <= '0;
        end else begin
            r_to_cnt        <= w_to_cnt_next;
            r_first         <= r_first & ~w_capture;
            r_fault         <= w_fault_next;
            r_adc_start     <= (w_state_next == c_st_req);
            r_reading_valid <= (r_state == c_st_update);
            if (w_fault_next) begin
                r_reading <= 8'hFF;
            end else if (r_state == c_st_update) begin
                r_reading <= w_avg;
            end
        end
    end

    temp_avg4 u_avg (
        .clk      (clk),
        .reset    (reset),
        .load_all (w_capture & r_first),
        .shift    (w_capture & ~r_first),
        .din      (adc_data),
        .avg      (w_avg)
    );

    assign adc_start     = r_adc_start;
    assign reading       = r_reading;
    assign reading_valid = r_reading_valid;
    assign sensor_fault  = r_fault;

endmodule
`default_nettype wire

// File: doc/temp_sampler.md
TEMP_SAMPLER -- requirements
Module: temp_sampler

Interface
REQ-001 SHALL have parameter SAMPLE_PERIOD, default 1000, giving the number of idle cycles between ADC conversion requests (minimum 2).
REQ-002 SHALL have parameter TIMEOUT, default 64, giving the maximum cycles to wait for ADC data after a request (minimum 2).
REQ-003 SHALL have parameter FAULT_LIMIT, default 3, giving the number of consecutive timeouts that declares a sensor fault.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port adc_start, output, 1 bit: one-cycle conversion request to the ADC.
REQ-007 SHALL have port adc_valid, input, 1 bit: ADC conversion result present on adc_data.
REQ-008 SHALL have port adc_data, input, 8 bits: raw unsigned temperature code.
REQ-009 SHALL have port reading, output, 8 bits: filtered temperature fed to the downstream alarm/shutdown controller.
REQ-010 SHALL have port reading_valid, output, 1 bit: one-cycle pulse when reading updates.
REQ-011 SHALL have port sensor_fault, output, 1 bit: sticky sensor-failure flag.

Function
REQ-012 SHALL implement the FSM states IDLE, REQ, WAIT and UPDATE.
REQ-013 IDLE SHALL count SAMPLE_PERIOD cycles and then go to REQ; the counter clears on entry to IDLE.
REQ-014 REQ SHALL assert adc_start for exactly one cycle, clear the timeout counter and go to WAIT.
REQ-015 WAIT SHALL sample adc_valid every cycle; adc_valid outside WAIT SHALL be ignored.
REQ-016 If adc_valid=1 in WAIT, SHALL capture adc_data into the 4-entry history shift register, clear the consecutive-timeout count and go to UPDATE.
REQ-017 If TIMEOUT WAIT cycles elapse without adc_valid, SHALL increment the consecutive-timeout count (saturating at FAULT_LIMIT), leave history and reading unchanged, and go to IDLE.
REQ-018 If adc_valid=1 arrives in the same cycle the timeout expires, SHALL treat it as valid data.
REQ-019 For the first valid sample after reset, SHALL load the sample into all four history entries.
REQ-020 UPDATE SHALL register reading = (h0+h1+h2+h3)>>2, using a 10-bit sum and truncating the fraction, SHALL assert reading_valid for that single cycle, and SHALL go to IDLE.
REQ-021 Latency SHALL be fixed: adc_valid captured at edge N gives reading and reading_valid at edge N+1.
REQ-022 When the consecutive-timeout count reaches FAULT_LIMIT, SHALL set sensor_fault=1 and keep it set until reset.
REQ-023 While sensor_fault=1, SHALL force reading to 8'hFF (fail-safe, so downstream asserts shutdown), SHALL keep requesting samples, and SHALL still pulse reading_valid on valid data.
REQ-024 The sampling loop SHALL continue indefinitely, with no dead states.

Reset
REQ-025 When reset=1 at a clock edge, SHALL enter IDLE with all counters 0, history cleared, the first-sample flag set, adc_start=0, reading=8'h00, reading_valid=0 and sensor_fault=0.
REQ-026 Reset SHALL take priority over every other event, including mid-WAIT and during UPDATE; a pending conversion is abandoned and its later adc_valid ignored.

Structure
REQ-027 The FSM state encoding and the default values of SAMPLE_PERIOD, TIMEOUT and FAULT_LIMIT SHALL be placed in the shared temperature package.
REQ-028 The 4-tap history and averaging SHALL be one sub-module, temp_avg4, which has the ports load_all, shift, din[7:0] and avg[7:0].
REQ-029 All outputs SHALL be registered, with no combinational input-to-output paths.

Verification
REQ-030 Bench SHALL check basic sample: SAMPLE_PERIOD=4, ADC returns 8'd100 two cycles after adc_start -> reading=100 with a one-cycle reading_valid one cycle after adc_valid.
REQ-031 Bench SHALL check averaging: after a first sample of 100, apply samples 200, 200, 200 -> readings 125, 150, 175; then apply 201 -> 200 (truncation, 801>>2).
REQ-032 Bench SHALL check timeout: TIMEOUT=8 with no adc_valid -> return to IDLE after 8 WAIT cycles, no reading_valid, reading unchanged, sensor_fault=0.
REQ-033 Bench SHALL check fault: 3 consecutive timeouts -> sensor_fault=1 and reading=8'hFF; later valid data -> reading stays 8'hFF with a reading_valid pulse; only reset clears the fault.
REQ-034 Bench SHALL check timeout recovery: 2 timeouts then valid 50 -> reading=50 and count cleared; 2 further timeouts -> sensor_fault stays 0.
REQ-035 Bench SHALL check reset mid-WAIT: assert reset, then deliver adc_valid=1 with data 8'd77 after reset is released -> data ignored, reading=0, and the next adc_start comes only after SAMPLE_PERIOD idle cycles.
